// File: rtl/ir_filter_sched_pkg.sv
// Shared types and constants for the IR filter scheduler.
package ir_filter_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      logic sof;
      logic sol;
      logic eol;
      logic eof;
   } mark_t;

   localparam int DRAIN_TO_DEF = 1024;

endpackage

// File: rtl/ir_filter_sched_wdog.sv
// DRAIN watchdog: counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th consecutive enabled cycle.
module ir_filter_sched_wdog
   import ir_filter_sched_pkg::*;
#(
   parameter int LIMIT = DRAIN_TO_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && (cnt_q >= CW'(LIMIT - 1));

   // next count: clear wins, otherwise advance while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expire_o)
         cnt_d = cnt_q + CW'(1);
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ir_filter_sched.sv
// IR filter scheduler: steers one frame of 3x3 windows to the filter engine
// chosen at start of frame and returns that engine's results downstream.
// Optional build macro IR_FILTER_SCHED_STATS_EN adds frame_cnt/err_cnt.
module ir_filter_sched
   import ir_filter_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_FILT   = 4,
   parameter int DRAIN_TO   = DRAIN_TO_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [1:0]                     cfg_sel,
   input  logic                           in_val,
   output logic                           in_rdy,
   input  logic [9*DATA_WIDTH-1:0]        in_data,
   input  logic                           in_sof,
   input  logic                           in_sol,
   input  logic                           in_eol,
   input  logic                           in_eof,
   output logic [NUM_FILT-1:0]            f_val,
   input  logic [NUM_FILT-1:0]            f_rdy,
   output logic [9*DATA_WIDTH-1:0]        f_data,
   output logic                           f_sof,
   output logic                           f_sol,
   output logic                           f_eol,
   output logic                           f_eof,
   input  logic [NUM_FILT-1:0]            r_val,
   output logic [NUM_FILT-1:0]            r_rdy,
   input  logic [NUM_FILT*DATA_WIDTH-1:0] r_data,
   input  logic [NUM_FILT-1:0]            r_sof,
   input  logic [NUM_FILT-1:0]            r_sol,
   input  logic [NUM_FILT-1:0]            r_eol,
   input  logic [NUM_FILT-1:0]            r_eof,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_sof,
   output logic                           out_sol,
   output logic                           out_eol,
   output logic                           out_eof,
   output logic                           busy,
   output logic [1:0]                     cur_sel
`ifdef IR_FILTER_SCHED_STATS_EN
   ,
   output logic [15:0]                    frame_cnt,
   output logic [7:0]                     err_cnt
`endif
);

   state_e                state_q, state_d;
   logic [1:0]            sel_q, sel_d;
   logic [NUM_FILT-1:0]   hit;
   logic                  rv, frdy, clamp_c, acc_out, wd_en, wd_clr, wd_exp;
   logic [DATA_WIDTH-1:0] rdat;
   mark_t                 rm;

   // windows and markers are broadcast; only f_val selects the engine
   assign f_data  = in_data;
   assign f_sof   = in_sof;
   assign f_sol   = in_sol;
   assign f_eol   = in_eol;
   assign f_eof   = in_eof;

   assign out_data = rdat;
   assign out_sof  = rm.sof;
   assign out_sol  = rm.sol;
   assign out_eol  = rm.eol;
   assign out_eof  = rm.eof;
   assign busy     = (state_q != ST_IDLE);
   assign cur_sel  = sel_q;
   assign clamp_c  = (int'(cfg_sel) >= NUM_FILT);
   assign acc_out  = out_val && out_rdy;

   // decode the latched engine and mux its ready/result lanes
   always_comb begin
      hit  = '0;
      rv   = 1'b0;
      frdy = 1'b0;
      rdat = '0;
      rm   = '0;
      for (int i = 0; i < NUM_FILT; i++) begin
         if (sel_q == 2'(i)) begin
            hit[i] = 1'b1;
            rv     = r_val[i];
            frdy   = f_rdy[i];
            rdat   = r_data[i*DATA_WIDTH +: DATA_WIDTH];
            rm.sof = r_sof[i];
            rm.sol = r_sol[i];
            rm.eol = r_eol[i];
            rm.eof = r_eof[i];
         end
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      in_rdy  = 1'b0;
      f_val   = '0;
      r_rdy   = '0;
      out_val = 1'b0;
      wd_en   = 1'b0;
      wd_clr  = 1'b1;
      // results only flow while a frame owns an engine; otherwise held back
      if (state_q == ST_RUN || state_q == ST_DRAIN) begin
         out_val = rv;
         r_rdy   = hit & {NUM_FILT{out_rdy}};
      end
      case (state_q)
         ST_IDLE: begin
            in_rdy = ~in_sof;
            if (in_val && in_sof) begin
               state_d = ST_ARM;
               sel_d   = clamp_c ? 2'd0 : cfg_sel;
            end
         end
         ST_ARM: state_d = ST_RUN;
         ST_RUN: begin
            f_val  = hit & {NUM_FILT{in_val}};
            in_rdy = frdy;
            if (in_val && frdy && in_eof) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            wd_clr = acc_out;
            wd_en  = ~acc_out;
            if ((acc_out && rm.eof) || wd_exp) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and engine-select registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   ir_filter_sched_wdog #(.LIMIT(DRAIN_TO)) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (wd_en),
      .clr_i    (wd_clr),
      .expire_o (wd_exp)
   );

`ifdef IR_FILTER_SCHED_STATS_EN
   logic        drop, clamp, abort, done;
   logic [15:0] frame_q;
   logic [7:0]  err_q;

   assign drop  = (state_q == ST_IDLE) && in_val && !in_sof;
   assign clamp = (state_q == ST_IDLE) && in_val && in_sof && clamp_c;
   assign abort = (state_q == ST_DRAIN) && !acc_out && wd_exp;
   assign done  = (state_q == ST_DRAIN) && acc_out && rm.eof;

   // completed-frame counter (wraps) and error counter (saturates)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
         err_q   <= '0;
      end else begin
         if (done) frame_q <= frame_q + 16'd1;
         if ((drop || clamp || abort) && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
   end

   assign frame_cnt = frame_q;
   assign err_cnt   = err_q;
`endif

endmodule
